// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding, default
// cycle constants and a small helper used to size the shared counter.
package pll_seq_pkg;

   typedef enum logic [1:0] {
      PLL_RESET = 2'd0,
      WAIT_LOCK = 2'd1,
      STABLE    = 2'd2,
      RUN       = 2'd3
   } state_t;

   localparam int DEF_RST_PULSE_CYCLES    = 16;
   localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
   localparam int DEF_LOCK_TIMEOUT_CYCLES = 500000;

   localparam logic [7:0] RELOCK_MAX = 8'd255;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchronizer for an input that is asynchronous
// to clk. Both stages clear on rst.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_reg;
   logic sync_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_reg <= 1'b0;
         sync_reg <= 1'b0;
      end else begin
         meta_reg <= d;
         sync_reg <= meta_reg;
      end
   end

   assign q = sync_reg;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL supervisor on the reference clock: pulses the PLL reset, waits for a
// stable lock window, then releases sys_rst; re-sequences on loss of lock.
module pll_reset_sequencer
   import pll_seq_pkg::*;
#(
   parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
   parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
   parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
   parameter int CNT_W = $clog2(max3(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES))
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pll_locked,
   output logic       pll_rst,
   output logic       sys_rst,
   output logic       ready,
   output logic       timeout_err,
   output logic [7:0] relock_count
);

   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

   logic             locked_s;
   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             pll_rst_reg, sys_rst_reg, ready_reg;
   logic             timeout_reg, timeout_next;
   logic [7:0]       relock_reg, relock_next;

   sync_2ff u_lock_sync (
      .clk (clk),
      .rst (rst),
      .d   (pll_locked),
      .q   (locked_s)
   );

   // The counter is shared by all timed states and restarts from zero on
   // every transition, so each state measures its own dwell time.
   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg + CNT_W'(1);
      timeout_next = timeout_reg;
      relock_next  = relock_reg;
      unique case (state_reg)
         PLL_RESET: begin
            if (cnt_reg == RST_LAST) begin
               state_next = WAIT_LOCK;
               cnt_next   = '0;
            end
         end
         WAIT_LOCK: begin
            // Lock wins over an expiring timeout on the same cycle.
            if (locked_s) begin
               state_next = STABLE;
               cnt_next   = '0;
            end else if (cnt_reg == TIMEOUT_LAST) begin
               state_next   = PLL_RESET;
               cnt_next     = '0;
               timeout_next = 1'b1;
            end
         end
         STABLE: begin
            if (!locked_s) begin
               state_next = WAIT_LOCK;
               cnt_next   = '0;
            end else if (cnt_reg == STABLE_LAST) begin
               state_next = RUN;
               cnt_next   = '0;
            end
         end
         RUN: begin
            cnt_next = '0;
            if (!locked_s) begin
               state_next  = PLL_RESET;
               relock_next = (relock_reg == RELOCK_MAX) ? relock_reg : relock_reg + 8'd1;
            end
         end
         default: begin
            state_next = PLL_RESET;
            cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= PLL_RESET;
         cnt_reg     <= '0;
         pll_rst_reg <= 1'b1;
         sys_rst_reg <= 1'b1;
         ready_reg   <= 1'b0;
         timeout_reg <= 1'b0;
         relock_reg  <= 8'd0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         pll_rst_reg <= (state_next == PLL_RESET);
         sys_rst_reg <= (state_next != RUN);
         ready_reg   <= (state_next == RUN);
         timeout_reg <= timeout_next;
         relock_reg  <= relock_next;
      end
   end

   assign pll_rst      = pll_rst_reg;
   assign sys_rst      = sys_rst_reg;
   assign ready        = ready_reg;
   assign timeout_err  = timeout_reg;
   assign relock_count = relock_reg;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short test parameters
// (reset pulse 4, stable window 8, lock timeout 32).
module tb_pll_reset_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pll_locked = 1'b0;
   logic       pll_rst;
   logic       sys_rst;
   logic       ready;
   logic       timeout_err;
   logic [7:0] relock_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pll_reset_sequencer #(
      .RST_PULSE_CYCLES    (4),
      .LOCK_STABLE_CYCLES  (8),
      .LOCK_TIMEOUT_CYCLES (32)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .pll_locked   (pll_locked),
      .pll_rst      (pll_rst),
      .sys_rst      (sys_rst),
      .ready        (ready),
      .timeout_err  (timeout_err),
      .relock_count (relock_count)
   );

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_pll_rst"}, 32'(pll_rst), 32'd1);
      check({tag, "_sys_rst"}, 32'(sys_rst), 32'd1);
      check({tag, "_ready"}, 32'(ready), 32'd0);
      check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
      check({tag, "_relock_count"}, 32'(relock_count), 32'd0);
   endtask

   // Hold rst for two edges; the first edge after return is E1.
   task automatic do_reset(input logic lock_val);
      rst = 1'b1;
      pll_locked = lock_val;
      step(2);
      rst = 1'b0;
   endtask

   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      while (!ready && n < 40) begin
         step(1);
         n++;
      end
      check(tag, 32'(ready), 32'd1);
   endtask

   initial begin
      // Normal bring-up with lock high throughout
      do_reset(1'b1);
      check_reset("reset");
      step(3);
      check("e3_pll_rst", 32'(pll_rst), 32'd1);
      step(1);
      check("e4_pll_rst", 32'(pll_rst), 32'd0);
      step(8);
      check("e12_sys_rst", 32'(sys_rst), 32'd1);
      check("e12_ready", 32'(ready), 32'd0);
      step(1);
      check("e13_sys_rst", 32'(sys_rst), 32'd0);
      check("e13_ready", 32'(ready), 32'd1);
      check("e13_timeout_err", 32'(timeout_err), 32'd0);
      $display("bring-up: ready at E13 ready=%0d sys_rst=%0d", ready, sys_rst);

      // Lock never present: timeout at E36, then recovery once lock arrives
      do_reset(1'b0);
      step(35);
      check("e35_timeout_err", 32'(timeout_err), 32'd0);
      check("e35_pll_rst", 32'(pll_rst), 32'd0);
      step(1);
      check("e36_timeout_err", 32'(timeout_err), 32'd1);
      check("e36_pll_rst", 32'(pll_rst), 32'd1);
      pll_locked = 1'b1;
      step(4);
      check("e40_pll_rst", 32'(pll_rst), 32'd0);
      step(8);
      check("e48_ready", 32'(ready), 32'd0);
      step(1);
      check("e49_ready", 32'(ready), 32'd1);
      check("e49_sys_rst", 32'(sys_rst), 32'd0);
      check("e49_timeout_sticky", 32'(timeout_err), 32'd1);
      $display("timeout: err=%0d ready=%0d after recovery", timeout_err, ready);

      // One-cycle lock glitch during STABLE restarts the window
      do_reset(1'b1);
      step(7);
      pll_locked = 1'b0;
      step(1);
      pll_locked = 1'b1;
      for (int e = 9; e <= 18; e++) begin
         step(1);
         check($sformatf("glitch_e%0d_pll_rst", e), 32'(pll_rst), 32'd0);
         check($sformatf("glitch_e%0d_ready", e), 32'(ready), 32'd0);
      end
      step(1);
      check("glitch_e19_ready", 32'(ready), 32'd1);
      check("glitch_relock_count", 32'(relock_count), 32'd0);
      $display("glitch: ready at E19 relock_count=%0d", relock_count);

      // Loss of lock in RUN
      pll_locked = 1'b0;
      step(2);
      check("loss_f2_sys_rst", 32'(sys_rst), 32'd0);
      check("loss_f2_ready", 32'(ready), 32'd1);
      step(1);
      check("loss_f3_sys_rst", 32'(sys_rst), 32'd1);
      check("loss_f3_pll_rst", 32'(pll_rst), 32'd1);
      check("loss_f3_ready", 32'(ready), 32'd0);
      check("loss_f3_relock_count", 32'(relock_count), 32'd1);
      pll_locked = 1'b1;
      step(3);
      check("loss_f6_pll_rst", 32'(pll_rst), 32'd1);
      step(1);
      check("loss_f7_pll_rst", 32'(pll_rst), 32'd0);
      step(8);
      check("loss_f15_ready", 32'(ready), 32'd0);
      step(1);
      check("loss_f16_ready", 32'(ready), 32'd1);
      check("loss_f16_relock_count", 32'(relock_count), 32'd1);
      $display("relock: ready again, relock_count=%0d", relock_count);

      // Repeated lock losses: counter saturates at 255
      for (int i = 0; i < 300; i++) begin
         pll_locked = 1'b0;
         step(3);
         check($sformatf("sat_%0d_relock_count", i), 32'(relock_count),
               (i + 2 > 255) ? 32'd255 : 32'(i + 2));
         pll_locked = 1'b1;
         wait_ready($sformatf("sat_%0d_ready_wait", i));
      end
      $display("saturation: relock_count=%0d after 301 losses", relock_count);

      // rst pulsed mid-RUN, then mid-STABLE
      rst = 1'b1;
      step(1);
      check_reset("rst_run");
      rst = 1'b0;
      step(6);
      check("stable_e6_sys_rst", 32'(sys_rst), 32'd1);
      check("stable_e6_pll_rst", 32'(pll_rst), 32'd0);
      rst = 1'b1;
      step(1);
      check_reset("rst_stable");
      rst = 1'b0;
      step(13);
      check("after_rst_e13_ready", 32'(ready), 32'd1);
      check("after_rst_relock_count", 32'(relock_count), 32'd0);
      $display("mid-sequence rst: ready=%0d relock_count=%0d", ready, relock_count);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
